// File: rtl/vx_icache_responder_pkg.sv
// Bus widths shared by the instruction-cache responder and its fetch-side clients.
package vx_icache_responder_pkg;

    localparam int ICACHE_ADDR_WIDTH = 30;
    localparam int ICACHE_TAG_WIDTH  = 8;
    localparam int IMEM_WORD_BYTES   = 4;

endpackage

// File: rtl/vx_icache_responder_queue.sv
// In-order response queue with first-word fall-through; pointers carry one extra wrap bit.
module vx_icache_responder_queue #(
    parameter int DATAW = 40,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [DATAW-1:0] data_in,
    output logic [DATAW-1:0] data_out,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATAW-1:0] store [2**PTR_W];
    logic [PTR_W:0]   rd_ptr;
    logic [PTR_W:0]   wr_ptr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = ((wr_ptr - rd_ptr) == (PTR_W+1)'(DEPTH));
    assign data_out = store[rd_ptr[PTR_W-1:0]];

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) store[wr_ptr[PTR_W-1:0]] <= data_in;
    end

endmodule

// File: rtl/vx_icache_responder.sv
// Instruction-memory responder: byte-enabled writes, fixed-latency tagged reads,
// credit-limited in-order response queue.
module vx_icache_responder
    import vx_icache_responder_pkg::*;
#(
    parameter int    MEM_WORDS      = 1024,
    parameter int    ADDR_WIDTH     = ICACHE_ADDR_WIDTH,
    parameter int    TAG_WIDTH      = ICACHE_TAG_WIDTH,
    parameter int    LATENCY        = 2,
    parameter int    RSP_QUEUE_SIZE = 4,
    parameter string INIT_FILE      = ""
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    input  logic                       req_rw,
    input  logic [ADDR_WIDTH-1:0]      req_addr,
    input  logic [IMEM_WORD_BYTES-1:0] req_byteen,
    input  logic [31:0]                req_data,
    input  logic [TAG_WIDTH-1:0]       req_tag,
    output logic                       req_ready,
    output logic                       rsp_valid,
    output logic [31:0]                rsp_data,
    output logic [TAG_WIDTH-1:0]       rsp_tag,
    input  logic                       rsp_ready,
    output logic                       oob_err
);

    localparam int WORD_W = IMEM_WORD_BYTES * 8;
    localparam int DATAW  = WORD_W + TAG_WIDTH;
    localparam int MEM_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int CNT_W  = $clog2(RSP_QUEUE_SIZE) + 1;

    logic [WORD_W-1:0]  mem [MEM_WORDS];
    logic [CNT_W-1:0]   outstanding;
    logic [LATENCY-1:0] pipe_valid;
    logic [DATAW-1:0]   pipe_data [LATENCY];
    logic [DATAW-1:0]   q_data;
    logic [MEM_AW-1:0]  word_idx;
    logic               addr_ok;
    logic               req_fire;
    logic               read_fire;
    logic               write_fire;
    logic               rsp_fire;
    logic               q_empty;
    logic               q_full;

    assign addr_ok    = (req_addr < ADDR_WIDTH'(MEM_WORDS));
    assign word_idx   = req_addr[MEM_AW-1:0];
    assign rsp_valid  = !q_empty;
    assign rsp_fire   = rsp_valid && rsp_ready;
    // A pop this cycle frees a credit, so a full responder can still accept.
    assign req_ready  = reset && ((outstanding < CNT_W'(RSP_QUEUE_SIZE)) || rsp_fire);
    assign req_fire   = req_valid && req_ready;
    assign read_fire  = req_fire && !req_rw;
    assign write_fire = req_fire && req_rw;
    assign {rsp_data, rsp_tag} = q_data;

    always_ff @(posedge clk) begin
        if (write_fire && addr_ok) begin
            for (int b = 0; b < IMEM_WORD_BYTES; b++) begin
                if (req_byteen[b]) mem[word_idx][b*8 +: 8] <= req_data[b*8 +: 8];
            end
        end
    end

    // Payload stages run free; only the valid bits need clearing on reset.
    always_ff @(posedge clk) begin
        pipe_data[0] <= {(addr_ok ? mem[word_idx] : WORD_W'(0)), req_tag};
        for (int s = 1; s < LATENCY; s++) pipe_data[s] <= pipe_data[s-1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_valid  <= '0;
            outstanding <= '0;
            oob_err     <= 1'b0;
        end else begin
            pipe_valid[0] <= read_fire;
            for (int s = 1; s < LATENCY; s++) pipe_valid[s] <= pipe_valid[s-1];
            if (read_fire && !rsp_fire)      outstanding <= outstanding + CNT_W'(1);
            else if (!read_fire && rsp_fire) outstanding <= outstanding - CNT_W'(1);
            if (req_fire && !addr_ok) oob_err <= 1'b1;
        end
    end

    vx_icache_responder_queue #(
        .DATAW (DATAW),
        .DEPTH (RSP_QUEUE_SIZE)
    ) u_rsp_queue (
        .clk      (clk),
        .reset    (reset),
        .push     (pipe_valid[LATENCY-1]),
        .pop      (rsp_fire),
        .data_in  (pipe_data[LATENCY-1]),
        .data_out (q_data),
        .empty    (q_empty),
        .full     (q_full)
    );

    // Credits reserve a slot for every read in flight, so this must never fire.
    assert property (@(posedge clk) disable iff (!reset)
        !(pipe_valid[LATENCY-1] && q_full && !rsp_fire))
        else $error("vx_icache_responder: response queue overflow");

endmodule

// File: tb/tb_vx_icache_responder.sv
// Directed bench: latency, credit limit, byte writes, out-of-range, async reset, streaming at LATENCY 1 and 4.
module tb_vx_icache_responder;
    import vx_icache_responder_pkg::*;

    localparam int AW        = ICACHE_ADDR_WIDTH;
    localparam int TW        = ICACHE_TAG_WIDTH;
    localparam int MEM_WORDS = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, req_valid, req_rw, req_ready, rsp_valid, rsp_ready, oob_err;
    logic [AW-1:0] req_addr;
    logic [3:0]    req_byteen;
    logic [31:0]   req_data, rsp_data;
    logic [TW-1:0] req_tag, rsp_tag;

    int n_checks = 0;
    int n_errors = 0;

    vx_icache_responder #(
        .MEM_WORDS      (MEM_WORDS),
        .LATENCY        (2),
        .RSP_QUEUE_SIZE (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_rw     (req_rw),
        .req_addr   (req_addr),
        .req_byteen (req_byteen),
        .req_data   (req_data),
        .req_tag    (req_tag),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_tag    (rsp_tag),
        .rsp_ready  (rsp_ready),
        .oob_err    (oob_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Returns one time unit after the rising edge; inputs are driven there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pat(input int g, input int a);
        return 32'hA500_0000 | 32'(g << 16) | 32'(a * 257);
    endfunction

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        req_valid  = 1'b1;
        req_rw     = 1'b1;
        req_addr   = a;
        req_data   = d;
        req_byteen = be;
        tick();
        req_valid  = 1'b0;
        req_rw     = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [TW-1:0] t);
        logic acc;
        acc       = 1'b0;
        req_valid = 1'b1;
        req_rw    = 1'b0;
        req_addr  = a;
        req_tag   = t;
        for (int i = 0; i < 20 && !acc; i++) begin
            #1 acc = req_ready;
            tick();
        end
        req_valid = 1'b0;
        if (!acc) check("rd_accept_timeout", 0, 1);
    endtask

    task automatic expect_rsp(input string name, input logic [31:0] d, input logic [TW-1:0] t);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (rsp_valid && rsp_ready) begin
                seen = 1'b1;
                check({name, "_tag"}, rsp_tag, t);
                check({name, "_data"}, rsp_data, d);
            end
            tick();
        end
        if (!seen) check({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        int acc_n;
        reset = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0;
        req_byteen = '0; req_data = '0; req_tag = '0; rsp_ready = 1'b0;
        repeat (3) tick();
        check("reset_req_ready", req_ready, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_oob_err", oob_err, 0);
        #2 reset = 1'b1;
        tick();
        check("post_reset_req_ready", req_ready, 1);

        wr(AW'(16), 32'hDEADBEEF, 4'hF);
        wr(AW'(3), 32'hAAAAAAAA, 4'hF);
        for (int i = 1; i <= 5; i++) wr(AW'(32 + i), 32'h1000_0000 + i, 4'hF);
        check("writes_no_rsp", rsp_valid, 0);

        // Exact two-cycle read latency
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_rw = 1'b0; req_addr = AW'(16); req_tag = TW'(8'h2A);
        #1 check("t1_req_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        check("t1_lat_edge0", rsp_valid, 0);
        tick();
        check("t1_lat_edge1", rsp_valid, 0);
        tick();
        check("t1_lat_edge2", rsp_valid, 1);
        check("t1_tag", rsp_tag, 8'h2A);
        check("t1_data", rsp_data, 32'hDEADBEEF);
        tick();
        check("t1_single_rsp", rsp_valid, 0);

        // Credit limit: four reads fit, the fifth waits for the first pop
        rsp_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            req_valid = 1'b1; req_rw = 1'b0; req_addr = AW'(32 + i); req_tag = TW'(i);
            #1 check($sformatf("t2_ready_%0d", i), req_ready, 1);
            tick();
        end
        req_addr = AW'(37);
        req_tag  = TW'(5);
        for (int i = 0; i < 4; i++) begin
            #1 check($sformatf("t2_full_%0d", i), req_ready, 0);
            tick();
        end
        check("t2_head_valid", rsp_valid, 1);
        check("t2_head_tag", rsp_tag, 1);
        check("t2_head_data", rsp_data, 32'h1000_0001);
        rsp_ready = 1'b1;
        #1 check("t2_ready_on_pop", req_ready, 1);
        tick();
        req_valid = 1'b0;
        for (int i = 2; i <= 5; i++) expect_rsp($sformatf("t2_rsp%0d", i), 32'h1000_0000 + i, TW'(i));
        for (int i = 0; i < 3; i++) begin
            check("t2_no_dup", rsp_valid, 0);
            tick();
        end

        // Byte-lane write followed immediately by a read of the same word
        wr(AW'(3), 32'h11223344, 4'b0101);
        rd(AW'(3), TW'(9));
        expect_rsp("t3_byteen", 32'hAA22AA44, TW'(9));
        wr(AW'(3), 32'hFFFFFFFF, 4'b0000);
        rd(AW'(3), TW'(10));
        expect_rsp("t3_byteen_zero", 32'hAA22AA44, TW'(10));
        check("t3_no_write_rsp", rsp_valid, 0);

        // Out-of-range read and write
        check("t4_oob_clear", oob_err, 0);
        rd(AW'(MEM_WORDS), TW'(7));
        check("t4_oob_set", oob_err, 1);
        expect_rsp("t4_oob_rd", 32'h0, TW'(7));
        wr(AW'(MEM_WORDS + 16), 32'h12345678, 4'hF);
        rd(AW'(16), TW'(8));
        expect_rsp("t4_oob_wr_dropped", 32'hDEADBEEF, TW'(8));
        acc_n = 0;
        req_valid = 1'b1; req_rw = 1'b0; req_addr = AW'(16);
        for (int i = 0; i < 100; i++) begin
            req_tag = TW'(i);
            #1 if (req_ready) acc_n++;
            tick();
        end
        req_valid = 1'b0;
        check("t4_clean_accepts", acc_n, 100);
        check("t4_oob_held", oob_err, 1);
        repeat (6) tick();
        check("t4_drained", rsp_valid, 0);

        // Asynchronous reset with reads in flight
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) rd(AW'(16), TW'(8'h31 + i));
        check("t5_pre_reset_valid", rsp_valid, 1);
        #2 reset = 1'b0;
        #1;
        check("t5_rsp_valid_async", rsp_valid, 0);
        check("t5_oob_async", oob_err, 0);
        check("t5_req_ready_async", req_ready, 0);
        tick();
        #2 reset = 1'b1;
        tick();
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t5_no_stale_%0d", i), rsp_valid, 0);
            tick();
        end
        req_valid = 1'b1; req_rw = 1'b0; req_addr = AW'(16); req_tag = TW'(8'h44);
        #1 check("t5_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        check("t5_lat0", rsp_valid, 0);
        tick();
        check("t5_lat1", rsp_valid, 0);
        tick();
        check("t5_lat2", rsp_valid, 1);
        check("t5_tag", rsp_tag, 8'h44);
        check("t5_data", rsp_data, 32'hDEADBEEF);
        tick();

        for (int i = 0; i < 3000 && !(g_stream[0].done && g_stream[1].done); i++) tick();
        check("stream_done", {g_stream[1].done, g_stream[0].done}, 2'b11);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // Streaming instances: LATENCY 1 (queue 4) and LATENCY 4 (queue 8)
    for (genvar g = 0; g < 2; g++) begin : g_stream
        localparam int LAT = (g == 0) ? 1 : 4;
        localparam int QS  = (g == 0) ? 4 : 8;

        logic          s_reset, s_req_valid, s_req_rw, s_req_ready, s_rsp_valid, s_rsp_ready, s_oob_err;
        logic [AW-1:0] s_req_addr;
        logic [3:0]    s_req_byteen;
        logic [31:0]   s_req_data, s_rsp_data;
        logic [TW-1:0] s_req_tag, s_rsp_tag;
        logic          done = 1'b0;

        vx_icache_responder #(
            .MEM_WORDS      (MEM_WORDS),
            .LATENCY        (LAT),
            .RSP_QUEUE_SIZE (QS)
        ) u_dut (
            .clk        (clk),
            .reset      (s_reset),
            .req_valid  (s_req_valid),
            .req_rw     (s_req_rw),
            .req_addr   (s_req_addr),
            .req_byteen (s_req_byteen),
            .req_data   (s_req_data),
            .req_tag    (s_req_tag),
            .req_ready  (s_req_ready),
            .rsp_valid  (s_rsp_valid),
            .rsp_data   (s_rsp_data),
            .rsp_tag    (s_rsp_tag),
            .rsp_ready  (s_rsp_ready),
            .oob_err    (s_oob_err)
        );

        initial begin
            logic [TW+31:0] sb [$];
            logic [TW+31:0] held;
            logic           held_live;
            logic [TW-1:0]  next_tag;
            int             n_acc;
            s_reset = 1'b0; s_req_valid = 1'b0; s_req_rw = 1'b0; s_req_addr = '0;
            s_req_byteen = 4'hF; s_req_data = '0; s_req_tag = '0; s_rsp_ready = 1'b0;
            held = '0; held_live = 1'b0; next_tag = '0; n_acc = 0;
            repeat (3) tick();
            s_reset = 1'b1;
            tick();
            for (int a = 0; a < 32; a++) begin
                s_req_valid = 1'b1; s_req_rw = 1'b1; s_req_addr = AW'(a); s_req_data = pat(g, a);
                tick();
            end
            s_req_rw = 1'b0;
            for (int cyc = 0; cyc < 360; cyc++) begin
                s_req_valid = 1'b1;
                s_req_addr  = AW'($urandom_range(0, 31));
                s_req_tag   = next_tag;
                s_rsp_ready = (cyc >= 300) ? 1'b1 : 1'($urandom_range(0, 1));
                #1;
                if (held_live) begin
                    check("stream_hold_valid", s_rsp_valid, 1);
                    check("stream_hold_payload", {s_rsp_tag, s_rsp_data}, held);
                end
                if (s_rsp_valid && s_rsp_ready) begin
                    if (sb.size() == 0) check("stream_unexpected_rsp", 1, 0);
                    else check("stream_order", {s_rsp_tag, s_rsp_data}, sb.pop_front());
                end
                if (s_req_ready) begin
                    sb.push_back({next_tag, pat(g, int'(s_req_addr))});
                    next_tag++;
                    if (cyc >= 300) n_acc++;
                end
                held_live = s_rsp_valid && !s_rsp_ready;
                held      = {s_rsp_tag, s_rsp_data};
                tick();
            end
            check("stream_throughput", n_acc, 60);
            s_req_valid = 1'b0;
            s_rsp_ready = 1'b1;
            for (int i = 0; i < 40 && sb.size() > 0; i++) begin
                if (s_rsp_valid) check("stream_drain", {s_rsp_tag, s_rsp_data}, sb.pop_front());
                tick();
            end
            check("stream_drained", sb.size(), 0);
            check("stream_idle", s_rsp_valid, 0);
            check("stream_no_oob", s_oob_err, 0);
            done = 1'b1;
        end
    end

endmodule
